// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS32 controller and its datapath muxes.
// MC_CTRL_ADDI_EN adds the ADDI_EX/ADDI_WB states for addi support.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    INIT      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXECUTE   = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    ILLEGAL   = 4'd11
`ifdef MC_CTRL_ADDI_EN
    ,ADDI_EX  = 4'd12,
    ADDI_WB   = 4'd13
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/multi_cycle_control_if.sv
// Opcode in, datapath mux selects and write enables out, between controller and datapath.
interface multi_cycle_control_if;
  logic [5:0] opcode;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state
  );

  modport slave (
    output opcode,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: maps the controller state onto datapath selects and strobes.
// Built with MC_CTRL_ADDI_EN, also decodes the ADDI_EX/ADDI_WB states.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = CTRL_NONE;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_write  = 1'b1;
      end
      DECODE:    ctrl.alu_src_b = SRCB_IMM_SH2;
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      ILLEGAL:   ctrl.illegal_op = 1'b1;
`ifdef MC_CTRL_ADDI_EN
      ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ADDI_WB:   ctrl.reg_write = 1'b1;
`endif
      default:   ctrl = CTRL_NONE;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Main control FSM for the multi-cycle MIPS32 datapath: state register, opcode latch, next state.
// MC_CTRL_ADDI_EN enables addi via ADDI_EX -> ADDI_WB; otherwise 001000 is illegal.
module multi_cycle_control (
  input  logic                  clk,
  input  logic                  rst_n,
  multi_cycle_control_if.master bus
);
  import mc_ctrl_pkg::*;

  // state | meaning
  // INIT/FETCH/DECODE | reset, IR load + PC+4, register read + branch target
  // MEM_ADDR/MEM_READ/MEM_WB/MEM_WRITE | lw/sw address, load, load write-back, store
  // EXECUTE/R_WB/BRANCH/JUMP/ILLEGAL | R-type ALU, R-type write-back, beq, j, bad opcode
  // ADDI_EX/ADDI_WB | addi ALU, addi write-back (MC_CTRL_ADDI_EN only)

  state_t     state_q;
  logic [5:0] op_q;
  ctrl_t      ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      op_q    <= '0;
    end else begin
      case (state_q)
        INIT:     state_q <= FETCH;
        FETCH:    state_q <= DECODE;
        DECODE: begin
          op_q <= bus.opcode;
          case (bus.opcode)
            OP_LW, OP_SW: state_q <= MEM_ADDR;
            OP_RTYPE:     state_q <= EXECUTE;
            OP_BEQ:       state_q <= BRANCH;
            OP_J:         state_q <= JUMP;
`ifdef MC_CTRL_ADDI_EN
            OP_ADDI:      state_q <= ADDI_EX;
`endif
            default:      state_q <= ILLEGAL;
          endcase
        end
        // Only the latched opcode is trusted once DECODE has passed.
        MEM_ADDR: state_q <= (op_q == OP_SW) ? MEM_WRITE : MEM_READ;
        MEM_READ: state_q <= MEM_WB;
        EXECUTE:  state_q <= R_WB;
`ifdef MC_CTRL_ADDI_EN
        ADDI_EX:  state_q <= ADDI_WB;
`endif
        default:  state_q <= FETCH;
      endcase
    end
  end

  mc_ctrl_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.illegal_op    = ctrl.illegal_op;
  assign bus.state         = state_q;

endmodule
